// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central pipeline hazard controller. Merges stall requests from IF/ID/EX/MEM
// into per-register stall/bubble controls, accepts exceptions and ERET from
// MEM, flushes the pipeline for one cycle, then holds a redirect PC until
// fetch accepts it.
//
// Optional feature macro: HAZARD_PERF_CNT_EN (stall-cycle and exception
// counters; when undefined both counter outputs are tied to zero).
//
// Ports
//   clk_i                 clock, all state updates on posedge
//   rst_i                 synchronous active-high reset
//   if/id/ex/mem_stallreq_i  per-stage stall requests
//   mem_exception_type_i  0 = none, else exception code of MEM instruction
//   cp0_epc_i             current EPC, used as target for ERET
//   redirect_ready_i      fetch accepts new_pc_o this cycle
//   stall_o / bubble_o    {MEM2WB,EX2MEM,ID2EX,IF2ID,PC} hold / insert-NOP
//   flush_o               clear all pipeline registers
//   exc_ack_o             one-cycle pulse, exception accepted
//   redirect_valid_o      new_pc_o valid, held until redirect_ready_i
//   new_pc_o              redirect target, keeps last value outside REDIRECT
//   perf_stall_cnt_o      RUN cycles with any stall
//   perf_exc_cnt_o        accepted exceptions
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal operation, stalls merged, exceptions may be accepted
// FLUSH    | single cycle clearing all pipeline registers
// REDIRECT | new_pc_o presented to fetch, waits for redirect_ready_i

module pipe_hazard_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000E
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_stallreq_i,
  input  logic        id_stallreq_i,
  input  logic        ex_stallreq_i,
  input  logic        mem_stallreq_i,
  input  logic [31:0] mem_exception_type_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        redirect_ready_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  bubble_o,
  output logic        flush_o,
  output logic        exc_ack_o,
  output logic        redirect_valid_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_exc_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        exc_accept;
  logic [4:0]  run_stall;

  // A MEM instruction that is itself stalled is not yet complete, so its
  // exception waits until the data access finishes.
  assign exc_accept = (mem_exception_type_i != 32'd0) && !mem_stallreq_i;

  // Highest requesting stage wins; it and everything upstream hold.
  always_comb begin
    run_stall = 5'b00000;
    if (mem_stallreq_i)     run_stall = 5'b01111;
    else if (ex_stallreq_i) run_stall = 5'b00111;
    else if (id_stallreq_i) run_stall = 5'b00011;
    else if (if_stallreq_i) run_stall = 5'b00001;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      new_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      new_pc_q <= new_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (exc_accept) begin
          state_d  = ST_FLUSH;
          new_pc_d = (mem_exception_type_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        end
      end
      ST_FLUSH:    state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready_i) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted so nothing downstream
  // (notably CP0 via exc_ack_o) acts on a cycle that is being discarded.
  always_comb begin
    stall_o          = 5'b00000;
    flush_o          = 1'b0;
    exc_ack_o        = 1'b0;
    redirect_valid_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        ST_RUN: begin
          if (exc_accept) exc_ack_o = 1'b1;
          else            stall_o   = run_stall;
        end
        ST_FLUSH:    flush_o = 1'b1;
        ST_REDIRECT: begin
          redirect_valid_o = 1'b1;
          stall_o          = 5'b00001;
        end
        default: ;
      endcase
    end
  end

  // A stage that proceeds while the stage below it holds must emit a NOP.
  assign bubble_o = {stall_o[3:0] & ~stall_o[4:1], 1'b0};
  assign new_pc_o = new_pc_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_exc_cnt_q, perf_exc_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_exc_cnt_d   = perf_exc_cnt_q;
    if ((state_q == ST_RUN) && (stall_o != 5'b00000)) perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    if (exc_ack_o) perf_exc_cnt_d = perf_exc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cnt_q <= 32'd0;
      perf_exc_cnt_q   <= 32'd0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_exc_cnt_q   <= perf_exc_cnt_d;
    end
  end

  assign perf_stall_cnt_o = perf_stall_cnt_q;
  assign perf_exc_cnt_o   = perf_exc_cnt_q;
`else
  assign perf_stall_cnt_o = 32'd0;
  assign perf_exc_cnt_o   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a cycle-count based reference model.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i;
  logic [31:0] mem_exception_type_i, cp0_epc_i;
  logic        redirect_ready_i;
  logic [4:0]  stall_o, bubble_o;
  logic        flush_o, exc_ack_o, redirect_valid_o;
  logic [31:0] new_pc_o, perf_stall_cnt_o, perf_exc_cnt_o;

  pipe_hazard_ctrl dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .if_stallreq_i        (if_stallreq_i),
    .id_stallreq_i        (id_stallreq_i),
    .ex_stallreq_i        (ex_stallreq_i),
    .mem_stallreq_i       (mem_stallreq_i),
    .mem_exception_type_i (mem_exception_type_i),
    .cp0_epc_i            (cp0_epc_i),
    .redirect_ready_i     (redirect_ready_i),
    .stall_o              (stall_o),
    .bubble_o             (bubble_o),
    .flush_o              (flush_o),
    .exc_ack_o            (exc_ack_o),
    .redirect_valid_o     (redirect_valid_o),
    .new_pc_o             (new_pc_o),
    .perf_stall_cnt_o     (perf_stall_cnt_o),
    .perf_exc_cnt_o       (perf_exc_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since an exception was acknowledged.
  // 0 = normal running, 1 = the flush cycle, >=2 = waiting for fetch.
  int          m_since;
  logic [31:0] m_new_pc;
  logic [31:0] m_stall_cnt, m_exc_cnt;

  // Last sampled outputs, for literal checks in the directed scenarios.
  logic [4:0]  s_stall, s_bubble;
  logic        s_flush, s_ack, s_rv;
  logic [31:0] s_new_pc, s_perf_stall, s_perf_exc;

  task automatic model_reset();
    m_since     = 0;
    m_new_pc    = 32'd0;
    m_stall_cnt = 32'd0;
    m_exc_cnt   = 32'd0;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic rst, input logic ifr, input logic idr,
                      input logic exr, input logic memr,
                      input logic [31:0] exc, input logic [31:0] epc,
                      input logic rdy);
    int   e_stall, e_bubble;
    logic e_flush, e_ack, e_rv;
    rst_i = rst; if_stallreq_i = ifr; id_stallreq_i = idr; ex_stallreq_i = exr;
    mem_stallreq_i = memr; mem_exception_type_i = exc; cp0_epc_i = epc;
    redirect_ready_i = rdy;
    @(negedge clk_i);
    s_stall = stall_o; s_bubble = bubble_o; s_flush = flush_o; s_ack = exc_ack_o;
    s_rv = redirect_valid_o; s_new_pc = new_pc_o;
    s_perf_stall = perf_stall_cnt_o; s_perf_exc = perf_exc_cnt_o;

    e_stall = 0; e_flush = 1'b0; e_ack = 1'b0; e_rv = 1'b0;
    if (m_since == 0) begin
      if (exc != 0 && !memr) e_ack = 1'b1;
      else if (memr) e_stall = 15;
      else if (exr)  e_stall = 7;
      else if (idr)  e_stall = 3;
      else if (ifr)  e_stall = 1;
    end else if (m_since == 1) begin
      e_flush = 1'b1;
    end else begin
      e_rv = 1'b1;
      e_stall = 1;
    end
    // The NOP lands just above the topmost held register.
    e_bubble = (e_stall + 1) & 30;

    if (!rst) begin
      chk("stall", {27'd0, s_stall}, e_stall);
      chk("bubble", {27'd0, s_bubble}, e_bubble);
      chk("flush", {31'd0, s_flush}, {31'd0, e_flush});
      chk("exc_ack", {31'd0, s_ack}, {31'd0, e_ack});
      chk("redirect_valid", {31'd0, s_rv}, {31'd0, e_rv});
      chk("new_pc", s_new_pc, m_new_pc);
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall", s_perf_stall, m_stall_cnt);
      chk("perf_exc", s_perf_exc, m_exc_cnt);
`else
      chk("perf_stall", s_perf_stall, 32'd0);
      chk("perf_exc", s_perf_exc, 32'd0);
`endif
    end

    if (rst) begin
      model_reset();
    end else begin
      if (m_since == 0 && e_stall != 0) m_stall_cnt = m_stall_cnt + 32'd1;
      if (e_ack) begin
        m_exc_cnt = m_exc_cnt + 32'd1;
        m_new_pc  = (exc == 32'h0000_000E) ? epc : 32'hBFC0_0380;
        m_since   = 1;
      end else if (m_since == 1) begin
        m_since = 2;
      end else if (m_since >= 2) begin
        m_since = rdy ? 0 : m_since + 1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  initial begin
    rst_i = 1'b1; if_stallreq_i = 1'b0; id_stallreq_i = 1'b0; ex_stallreq_i = 1'b0;
    mem_stallreq_i = 1'b0; mem_exception_type_i = 32'd0; cp0_epc_i = 32'd0;
    redirect_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state
    idle(1'b0);
    chk("rst_stall", {27'd0, s_stall}, 32'd0);
    chk("rst_new_pc", s_new_pc, 32'd0);

    // EX multicycle stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("ex_stall_lit", {27'd0, s_stall}, 32'h07);
      chk("ex_bubble_lit", {27'd0, s_bubble}, 32'h08);
    end
    idle(1'b0);
    chk("ex_release", {27'd0, s_stall}, 32'd0);

    // ID and MEM together: MEM wins
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0);
    chk("idmem_stall_lit", {27'd0, s_stall}, 32'h0F);
    chk("idmem_bubble_lit", {27'd0, s_bubble}, 32'h10);

    // Exception 0xC with fetch immediately ready
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC, 32'h1111_0000, 1'b1);
    chk("exc_ack_T", {31'd0, s_ack}, 32'd1);
    idle(1'b1);
    chk("flush_T1", {31'd0, s_flush}, 32'd1);
    idle(1'b1);
    chk("rv_T2", {31'd0, s_rv}, 32'd1);
    chk("vector_T2", s_new_pc, 32'hBFC0_0380);
    idle(1'b0);
    chk("run_T3", {31'd0, s_rv}, 32'd0);

    // ERET with fetch stalled for 4 cycles
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hE, 32'h8000_1234, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hC, 32'd0, 1'b0);
      chk("eret_pc_lit", s_new_pc, 32'h8000_1234);
      chk("eret_stall_lit", {27'd0, s_stall}, 32'h01);
    end
    idle(1'b1);
    idle(1'b0);
    chk("eret_pc_kept", s_new_pc, 32'h8000_1234);

    // Exception held off by a MEM stall for 2 cycles
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'd0, 1'b1);
      chk("memstall_no_ack", {31'd0, s_ack}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'd0, 1'b1);
    chk("memstall_ack", {31'd0, s_ack}, 32'd1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Reset while redirecting
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'd0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(1'b0);
    chk("rst_redir_rv", {31'd0, s_rv}, 32'd0);
    chk("rst_redir_pc", s_new_pc, 32'd0);
    chk("rst_redir_perf_stall", s_perf_stall, 32'd0);
    chk("rst_redir_perf_exc", s_perf_exc, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] exc;
      int sel;
      exc = 32'd0;
      sel = $urandom_range(0, 7);
      if (sel == 0) exc = 32'hC;
      else if (sel == 1) exc = 32'hE;
      else if (sel == 2) exc = $urandom() | 32'd1;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           exc, $urandom(), ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
